// File: rtl/bcd_scan4.sv
// bcd_scan4: four-digit multiplexed 7-segment scanner for BCD data.
// Captures DIN into a hold register on LAT, walks one digit per PRESCALE
// clocks, decodes to active-high segments with optional leading-zero
// blanking, and flags any captured non-BCD nibble until reset.
module bcd_scan4 #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        CLK,
    input  logic        CD,
    input  logic [15:0] DIN,
    input  logic        LAT,
    input  logic        EN,
    input  logic        BLANK,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic [1:0]  IDX,
    output logic        ERR
);

    localparam int unsigned     PCW     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0]  PC_LAST = PCW'(PRESCALE - 1);

    logic [15:0]    r_hold;
    logic [PCW-1:0] r_pc;
    logic [1:0]     r_idx;
    logic           r_err;

    logic           w_bad;
    logic [3:0]     w_digit;
    logic [3:0]     w_nz_above;
    logic           w_blank;
    logic [6:0]     w_seg;

    // Flag any DIN nibble outside 0..9 at capture time.
    always_comb begin
        w_bad = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (DIN[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // Capture register and sticky non-BCD flag.
    always_ff @(posedge CLK) begin
        if (CD) begin
            r_hold <= '0;
            r_err  <= 1'b0;
        end else if (LAT) begin
            r_hold <= DIN;
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Prescaler and digit index; both freeze while EN is low.
    always_ff @(posedge CLK) begin
        if (CD) begin
            r_pc  <= '0;
            r_idx <= '0;
        end else if (EN) begin
            if (r_pc == PC_LAST) begin
                r_pc  <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pc  <= r_pc + PCW'(1);
            end
        end
    end

    // Digit k is a leading zero when it and all higher digits are zero;
    // invalid nibbles are nonzero and therefore never blanked.
    always_comb begin
        w_nz_above[3] = |r_hold[15:12];
        w_nz_above[2] = w_nz_above[3] | (|r_hold[11:8]);
        w_nz_above[1] = w_nz_above[2] | (|r_hold[7:4]);
        w_nz_above[0] = w_nz_above[1] | (|r_hold[3:0]);
        w_digit       = r_hold[{r_idx, 2'b00} +: 4];
        w_blank       = BLANK && (r_idx != 2'd0) && !w_nz_above[r_idx];
    end

    // BCD to 7-segment decode, bit 0 = a ... bit 6 = g; non-BCD shows "-".
    always_comb begin
        case (w_digit)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h40;
        endcase
    end

    // Output drive: segments follow HOLD regardless of EN; only AN is gated.
    always_comb begin
        SEG = w_blank ? 7'h00 : w_seg;
        AN  = EN ? (4'b0001 << r_idx) : 4'b0000;
        IDX = r_idx;
        ERR = r_err;
    end

endmodule
